// File: rtl/fixed_point_div.sv
// Multi-cycle saturating signed fixed-point divider (restoring long division,
// one quotient bit per clock) with valid/ready handshake on input side.
module fixed_point_div #(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] a,
  input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] b,
  output logic                                                out_valid,
  output logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] result,
  output logic                                                div_by_zero
);

  localparam int N  = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
  localparam int F  = FRACTIONAL_PART_WIDTH;
  localparam int NF = N + F;
  localparam int CW = $clog2(NF + 1);

  localparam logic [N-1:0]  MAX_POSITIVE_NUMBER = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  MIN_NEGATIVE_NUMBER = {1'b1, {(N-1){1'b0}}};
  localparam logic [NF-1:0] MAX_POS_MAG         = NF'(MAX_POSITIVE_NUMBER);
  localparam logic [NF-1:0] MIN_NEG_MAG         = NF'(MIN_NEGATIVE_NUMBER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    rem_q, rem_d;
  logic [NF-1:0] dvd_q, dvd_d;
  logic [NF-1:0] quo_q, quo_d;
  logic [N-1:0]  divisor_q, divisor_d;
  logic          sign_q, sign_d;
  logic          sign_a_q, sign_a_d;
  logic          zero_q, zero_d;
  logic [N-1:0]  result_q, result_d;
  logic          dbz_q, dbz_d;
  logic          out_valid_q, out_valid_d;

  logic [N-1:0]  mag_a, mag_b;
  logic [N:0]    rem_shift;
  logic          rem_ge;

  assign mag_a     = a[N-1] ? (~a + N'(1)) : a;
  assign mag_b     = b[N-1] ? (~b + N'(1)) : b;
  // Remainder stays below |b| <= 2^(N-1), so the shifted value fits in N+1 bits.
  assign rem_shift = {rem_q[N-1:0], dvd_q[NF-1]};
  assign rem_ge    = rem_shift >= {1'b0, divisor_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    quo_d       = quo_q;
    divisor_d   = divisor_q;
    sign_d      = sign_q;
    sign_a_d    = sign_a_q;
    zero_d      = zero_q;
    result_d    = result_q;
    dbz_d       = dbz_q;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d    = a[N-1] ^ b[N-1];
          sign_a_d  = a[N-1];
          zero_d    = (b == '0);
          divisor_d = mag_b;
          dvd_d     = NF'(mag_a) << F;
          rem_d     = '0;
          quo_d     = '0;
          cnt_d     = CW'(NF);
          state_d   = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        dvd_d = dvd_q << 1;
        if (rem_ge) begin
          rem_d = rem_shift - {1'b0, divisor_q};
          quo_d = {quo_q[NF-2:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          quo_d = {quo_q[NF-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        out_valid_d = 1'b1;
        dbz_d       = zero_q;
        if (zero_q) begin
          result_d = sign_a_q ? MIN_NEGATIVE_NUMBER : MAX_POSITIVE_NUMBER;
        end else if (!sign_q) begin
          result_d = (quo_q > MAX_POS_MAG) ? MAX_POSITIVE_NUMBER : quo_q[N-1:0];
        end else begin
          // q == 2^(N-1) negates to exactly MIN_NEGATIVE_NUMBER.
          result_d = (quo_q > MIN_NEG_MAG) ? MIN_NEGATIVE_NUMBER
                                           : (~quo_q[N-1:0] + N'(1));
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      sign_q      <= 1'b0;
      sign_a_q    <= 1'b0;
      zero_q      <= 1'b0;
      result_q    <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      quo_q       <= quo_d;
      divisor_q   <= divisor_d;
      sign_q      <= sign_d;
      sign_a_q    <= sign_a_d;
      zero_q      <= zero_d;
      result_q    <= result_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fixed_point_div.sv
// Self-checking bench for fixed_point_div: directed and random operands
// compared against an integer-arithmetic reference of the saturating quotient.
module tb_fixed_point_div;

  localparam int LATENCY = 26;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic [15:0] result;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  fixed_point_div #(
    .INTEGER_PART_WIDTH   (8),
    .FRACTIONAL_PART_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .result     (result),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {div_by_zero, result} from plain integer arithmetic.
  function automatic logic [16:0] model(input logic [15:0] ta, input logic [15:0] tb_);
    longint sa, sb, ma, mb, q, r;
    sa = longint'($signed(ta));
    sb = longint'($signed(tb_));
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (sb == 0) return {1'b1, (sa < 0) ? 16'h8000 : 16'h7FFF};
    q = (ma * 256) / mb;
    if ((sa < 0) == (sb < 0)) r = (q > 32767) ? 32767 : q;
    else                      r = (q > 32768) ? -32768 : -q;
    return {1'b0, 16'(r)};
  endfunction

  // Called at the acceptance edge; returns #1 into the out_valid cycle.
  task automatic wait_done(input bit hold, output int lat);
    int ready_bad;
    lat = 0;
    ready_bad = 0;
    for (int c = 1; c <= 60; c++) begin
      #1;
      if (!hold) in_valid = 1'b0;
      if (out_valid) begin
        lat = c;
        break;
      end
      if (in_ready) ready_bad++;
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk);
    end
    chk("latency", lat, LATENCY);
    chk("in_ready_low_during_op", ready_bad, 0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_);
    int lat;
    logic [16:0] exp;
    exp = model(ta, tb_);
    @(negedge clk);
    a = ta;
    b = tb_;
    in_valid = 1'b1;
    @(posedge clk);
    wait_done(1'b0, lat);
    chk({tag, "_result"}, result, exp[15:0]);
    chk({tag, "_dbz"}, div_by_zero, exp[16]);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [16:0] e1, e2;
    logic [15:0] ra, rb, a2, b2;

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_dbz", div_by_zero, 1'b0);
    rst = 1'b0;

    run_op("3_div_2",      16'h0300, 16'h0200);
    chk("3_div_2_exact", result, 16'h0180);
    run_op("m7p5_div_2p5", 16'hF880, 16'h0280);
    chk("m7p5_exact", result, 16'hFD00);
    run_op("trunc_pos",    16'h0100, 16'h0300);
    chk("trunc_pos_exact", result, 16'h0055);
    run_op("trunc_neg",    16'hFF00, 16'h0300);
    chk("trunc_neg_exact", result, 16'hFFAB);
    run_op("sat_pos",      16'h6400, 16'h0080);
    run_op("min_div_m1",   16'h8000, 16'hFF00);
    run_op("min_div_1",    16'h8000, 16'h0100);
    chk("min_div_1_exact", result, 16'h8000);
    run_op("sat_neg",      16'h9C00, 16'h0080);
    run_op("zero_div_pos", 16'h0000, 16'h0123);
    run_op("dbz_neg",      16'hFF00, 16'h0000);
    chk("dbz_neg_exact", result, 16'h8000);
    run_op("dbz_zero",     16'h0000, 16'h0000);
    chk("dbz_zero_exact", result, 16'h7FFF);
    run_op("min_div_min",  16'h8000, 16'h8000);
    run_op("small_div",    16'h0001, 16'h7FFF);

    // Result is held and out_valid is a single pulse.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_result", result, 16'h0000);
    chk("pulse_out_valid", out_valid, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = (i % 10 == 9) ? 16'h0000 : 16'($urandom);
      run_op("rand", ra, rb);
    end

    // Back-to-back with in_valid held and operands churning.
    ra = 16'h0500;
    rb = 16'hFE00;
    a2 = 16'h7F00;
    b2 = 16'h0040;
    e1 = model(ra, rb);
    e2 = model(a2, b2);
    @(negedge clk);
    a = ra;
    b = rb;
    in_valid = 1'b1;
    @(posedge clk);
    wait_done(1'b1, lat);
    chk("b2b_first_result", result, e1[15:0]);
    chk("b2b_ready_in_valid_cycle", in_ready, 1'b1);
    a = a2;
    b = b2;
    @(posedge clk);
    wait_done(1'b1, lat);
    in_valid = 1'b0;
    chk("b2b_second_result", result, e2[15:0]);
    chk("b2b_second_dbz", div_by_zero, e2[16]);
    @(posedge clk);
    #1;
    chk("b2b_no_third", in_ready, 1'b1);

    // Reset in the middle of a division.
    @(negedge clk);
    a = 16'h0300;
    b = 16'h0100;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_result", result, 16'h0000);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    chk("midrst_no_stray_valid", pulses, 0);
    run_op("after_rst", 16'h0300, 16'h0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
